// File: rtl/mem_port_arbiter.sv
// Shares the data-memory read/write port between the CPU pipeline and a DMA/debug requester.
// CPU has priority; a saturating wait counter forces a single-cycle steal for a starved DMA request.
module mem_port_arbiter #(
    parameter int MAX_WAIT    = 16,
    parameter int WAIT_W      = 5,
    parameter bit PROTECT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_pause,
    input  logic [7:0] cpu_readaddr,
    input  logic [7:0] cpu_writeaddr,
    input  logic [7:0] cpu_writedata,
    input  logic       cpu_write_en,
    output logic       cpu_stall,
    output logic [7:0] cpu_readdata,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic       dma_err,
    output logic       dma_rvalid,
    output logic [7:0] dma_rdata,
    output logic [7:0] mem_readaddr,
    output logic [7:0] mem_writeaddr,
    output logic [7:0] mem_writedata,
    output logic       mem_write_en,
    output logic       mem_pause,
    input  logic [7:0] mem_readdata
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              last_dma_rd_q, last_dma_rd_d;
    logic              last_cpu_q, last_cpu_d;
    logic [7:0]        cpu_hold_q, cpu_hold_d;
    logic [7:0]        dma_hold_q, dma_hold_d;

    logic dma_prot;
    logic forced;
    logic dma_win;

    always_comb begin
        dma_prot = PROTECT_LOW && dma_req && (dma_addr[7:4] == 4'h0);
        forced   = dma_req && !dma_prot && (wait_cnt_q == MAX_W);
        dma_win  = !reset && (forced || (dma_req && !dma_prot && !cpu_req));

        dma_gnt   = dma_win;
        dma_err   = !reset && dma_prot;
        cpu_stall = dma_win && cpu_req;

        if (dma_win) begin
            mem_readaddr  = dma_addr;
            mem_writeaddr = dma_addr;
            mem_writedata = dma_wdata;
            mem_write_en  = dma_we;
            mem_pause     = 1'b0;
        end else begin
            mem_readaddr  = cpu_readaddr;
            mem_writeaddr = cpu_writeaddr;
            mem_writedata = cpu_writedata;
            mem_write_en  = cpu_write_en && !reset;
            mem_pause     = cpu_pause;
        end

        // Read data lands one cycle after the access; the owner flags say whose it is.
        dma_rvalid   = !reset && last_dma_rd_q;
        dma_rdata    = reset ? 8'h00 : (last_dma_rd_q ? mem_readdata : dma_hold_q);
        cpu_readdata = reset ? 8'h00 : (last_cpu_q ? mem_readdata : cpu_hold_q);

        if (reset || !dma_req || dma_win || dma_prot)
            wait_cnt_d = '0;
        else if (wait_cnt_q == MAX_W)
            wait_cnt_d = wait_cnt_q;
        else
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);

        last_dma_rd_d = dma_win && !dma_we;
        last_cpu_d    = !reset && !dma_win && !cpu_pause;
        cpu_hold_d    = cpu_readdata;
        dma_hold_d    = dma_rdata;
    end

    always_ff @(posedge clk) begin
        wait_cnt_q    <= wait_cnt_d;
        last_dma_rd_q <= last_dma_rd_d;
        last_cpu_q    <= last_cpu_d;
        cpu_hold_q    <= cpu_hold_d;
        dma_hold_q    <= dma_hold_d;
    end

endmodule
